// File: rtl/ram_data_arbiter.sv
// rtl/ram_data_arbiter.sv - round-robin arbiter sharing the ram data port between two requesters
module ram_data_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_wEn,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_read_data,
    input  logic                  m1_req,
    input  logic                  m1_wEn,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_read_data,
    output logic                  wEn,
    output logic [ADDR_WIDTH-1:0] d_address,
    output logic [DATA_WIDTH-1:0] d_write_data,
    input  logic [DATA_WIDTH-1:0] d_read_data,
    output logic                  busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic       grant_id;
    logic       pending_write;
    logic       winner;
    logic       any_req;

    // Pick the winner: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            winner = ~last_grant;
        end else if (m1_req) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

    // Grant, capture request fields, perform the access and return read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            grant_id      <= 1'b0;
            pending_write <= 1'b0;
            d_address     <= '0;
            d_write_data  <= '0;
            m0_read_data  <= '0;
            m1_read_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id      <= winner;
                        last_grant    <= winner;
                        d_address     <= winner ? m1_address    : m0_address;
                        d_write_data  <= winner ? m1_write_data : m0_write_data;
                        pending_write <= winner ? m1_wEn        : m0_wEn;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!pending_write) begin
                        if (grant_id) begin
                            m1_read_data <= d_read_data;
                        end else begin
                            m0_read_data <= d_read_data;
                        end
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so an asynchronous reset clears them at once.
    always_comb begin
        wEn    = (state == ACCESS) && pending_write;
        m0_ack = (state == DONE) && !grant_id;
        m1_ack = (state == DONE) && grant_id;
        busy   = (state == ACCESS) || (state == DONE);
    end

endmodule

// File: tb/tb_ram_data_arbiter.sv
// tb/tb_ram_data_arbiter.sv - directed self-checking bench for ram_data_arbiter
module tb_ram_data_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m0_wEn = 1'b0;
    logic [15:0] m0_address = '0;
    logic [31:0] m0_write_data = '0;
    logic        m0_ack;
    logic [31:0] m0_read_data;
    logic        m1_req = 1'b0, m1_wEn = 1'b0;
    logic [15:0] m1_address = '0;
    logic [31:0] m1_write_data = '0;
    logic        m1_ack;
    logic [31:0] m1_read_data;
    logic        wEn;
    logic [15:0] d_address;
    logic [31:0] d_write_data;
    logic [31:0] d_read_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int we_cycles = 0;
    int m1_ack_cnt = 0;

    logic [31:0] mem [0:255];

    ram_data_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_wEn(m0_wEn), .m0_address(m0_address),
        .m0_write_data(m0_write_data), .m0_ack(m0_ack), .m0_read_data(m0_read_data),
        .m1_req(m1_req), .m1_wEn(m1_wEn), .m1_address(m1_address),
        .m1_write_data(m1_write_data), .m1_ack(m1_ack), .m1_read_data(m1_read_data),
        .wEn(wEn), .d_address(d_address), .d_write_data(d_write_data),
        .d_read_data(d_read_data), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural ram data port: combinational read, write on the rising edge.
    assign d_read_data = mem[d_address[7:0]];
    always @(posedge clock) if (wEn) mem[d_address[7:0]] <= d_write_data;

    // Observation counters sampled away from the active edge.
    always @(negedge clock) begin
        if (wEn) we_cycles++;
        if (m1_ack) m1_ack_cnt++;
    end

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive(input int m, input logic we, input logic [15:0] a, input logic [31:0] wd);
        if (m == 0) begin
            m0_req = 1'b1; m0_wEn = we; m0_address = a; m0_write_data = wd;
        end else begin
            m1_req = 1'b1; m1_wEn = we; m1_address = a; m1_write_data = wd;
        end
    endtask

    task automatic wait_ack(output int who, output int lat);
        who = -1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (m0_ack) begin who = 0; lat = i; break; end
            if (m1_ack) begin who = 1; lat = i; break; end
        end
    endtask

    task automatic txn(input int m, input logic we, input logic [15:0] a, input logic [31:0] wd,
                       output logic [31:0] rd);
        int who, lat;
        @(negedge clock);
        drive(m, we, a, wd);
        wait_ack(who, lat);
        checks++;
        if (who !== m) begin
            errors++;
            $display("FAIL txn_ack_owner: got %0d expected %0d", who, m);
        end
        rd = (m == 0) ? m0_read_data : m1_read_data;
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({wEn, busy, m0_ack, m1_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000", {wEn, busy, m0_ack, m1_ack});
        end
        @(negedge clock);
        checks++;
        if (m0_read_data !== 32'h0 || m1_read_data !== 32'h0 || d_address !== 16'h0 || d_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: got rd0=%h rd1=%h addr=%h wd=%h expected all 0",
                     m0_read_data, m1_read_data, d_address, d_write_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        int who, lat;
        int m1_before;
        m1_before = m1_ack_cnt;
        @(negedge clock);
        we_cycles = 0;
        drive(0, 1'b1, 16'd16, 32'd8);
        @(negedge clock);
        checks++;
        if (wEn !== 1'b1 || d_address !== 16'd16 || d_write_data !== 32'd8 || busy !== 1'b1) begin
            errors++;
            $display("FAIL write_access: got wEn=%b addr=%0d data=%0d busy=%b expected 1 16 8 1",
                     wEn, d_address, d_write_data, busy);
        end
        wait_ack(who, lat);
        checks++;
        if (who !== 0 || lat !== 1) begin
            errors++;
            $display("FAIL write_ack_latency: got who=%0d lat=%0d expected who=0 lat=1 (2 total)", who, lat);
        end
        m0_req = 1'b0;
        @(negedge clock);
        checks++;
        if (we_cycles !== 1 || mem[16] !== 32'd8) begin
            errors++;
            $display("FAIL write_effect: got we_cycles=%0d mem16=%h expected 1 00000008", we_cycles, mem[16]);
        end
        checks++;
        if (m1_ack_cnt !== m1_before || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_m1_quiet: got m1_acks=%0d busy=%b expected %0d 0",
                     m1_ack_cnt - m1_before, busy, 0);
        end
    endtask

    task automatic test_read_back();
        logic [31:0] rd;
        we_cycles = 0;
        txn(0, 1'b0, 16'd16, 32'hDEAD, rd);
        checks++;
        if (rd !== 32'h8 || we_cycles !== 0) begin
            errors++;
            $display("FAIL read_back: got data=%h we_cycles=%0d expected 00000008 0", rd, we_cycles);
        end
    endtask

    task automatic test_simultaneous();
        int who1, who2, lat;
        logic [31:0] rd;
        apply_reset();
        drive(0, 1'b1, 16'd20, 32'd32);
        drive(1, 1'b1, 16'd24, 32'd31);
        wait_ack(who1, lat);
        if (who1 == 0) m0_req = 1'b0;
        wait_ack(who2, lat);
        m0_req = 1'b0;
        m1_req = 1'b0;
        checks++;
        if (who1 !== 0 || who2 !== 1) begin
            errors++;
            $display("FAIL simultaneous_order: got %0d,%0d expected 0,1", who1, who2);
        end
        txn(0, 1'b0, 16'd20, 32'h0, rd);
        checks++;
        if (rd !== 32'h20) begin
            errors++;
            $display("FAIL simultaneous_read20: got %h expected 00000020", rd);
        end
        txn(1, 1'b0, 16'd24, 32'h0, rd);
        checks++;
        if (rd !== 32'h1F) begin
            errors++;
            $display("FAIL simultaneous_read24: got %h expected 0000001f", rd);
        end
    endtask

    task automatic test_contention();
        int who, lat;
        logic [31:0] exp_m1;
        apply_reset();
        drive(0, 1'b0, 16'd20, 32'h0);
        drive(1, 1'b0, 16'd24, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(who, lat);
            exp_m1 = (k >= 1) ? 32'h1F : 32'h0;
            checks++;
            if (who !== (k % 2) || m0_read_data !== 32'h20 || m1_read_data !== exp_m1) begin
                errors++;
                $display("FAIL contention_%0d: got who=%0d rd0=%h rd1=%h expected who=%0d rd0=00000020 rd1=%h",
                         k, who, m0_read_data, m1_read_data, k % 2, exp_m1);
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd;
        int m1_before;
        @(negedge clock);
        drive(1, 1'b1, 16'd28, 32'd11);
        @(negedge clock);
        checks++;
        if (wEn !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_access: got wEn=%b expected 1", wEn);
        end
        m1_before = m1_ack_cnt;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (wEn !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_wEn_drop: got wEn=%b busy=%b expected 0 0", wEn, busy);
        end
        m1_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (m1_ack_cnt !== m1_before || mem[28] !== 32'h0) begin
            errors++;
            $display("FAIL midreset_no_effect: got acks=%0d mem28=%h expected 0 00000000",
                     m1_ack_cnt - m1_before, mem[28]);
        end
        txn(1, 1'b0, 16'd28, 32'h0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL midreset_read28: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_field_change();
        int who, lat;
        logic [31:0] rd;
        @(negedge clock);
        drive(0, 1'b1, 16'd32, 32'd1);
        @(negedge clock);
        m0_address = 16'd36;
        m0_write_data = 32'd5;
        #1;
        checks++;
        if (d_address !== 16'd32 || d_write_data !== 32'd1) begin
            errors++;
            $display("FAIL field_hold: got addr=%0d data=%0d expected 32 1", d_address, d_write_data);
        end
        wait_ack(who, lat);
        m0_req = 1'b0;
        checks++;
        if (who !== 0) begin
            errors++;
            $display("FAIL field_ack: got %0d expected 0", who);
        end
        txn(0, 1'b0, 16'd32, 32'h0, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL field_read32: got %h expected 00000001", rd);
        end
        txn(0, 1'b0, 16'd36, 32'h0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL field_read36: got %h expected 00000000", rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_single_write();
        test_read_back();
        test_simultaneous();
        test_contention();
        test_reset_mid_access();
        test_field_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_data_arbiter.md
Name: ram_data_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single data port (wEn / d_address / d_write_data / d_read_data) of the dual-port ram.
- Requester 0 is the processor load/store stage; requester 1 is the program loader/debug port.
- The instruction port of the ram is not touched by this block.
- Each transaction takes a fixed 3 cycles. Exactly one requester owns the data port at a time.

Parameters:
- DATA_WIDTH, 32, width of data words; matches ram.
- ADDR_WIDTH, 16, width of addresses; matches ram.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  requester 0 transaction request; held high until m0_ack is seen.
- m0_wEn  input  1  requester 0: 1 = write, 0 = read.
- m0_address  input  ADDR_WIDTH  requester 0 address.
- m0_write_data  input  DATA_WIDTH  requester 0 write data.
- m0_ack  output  1  one-cycle completion pulse to requester 0.
- m0_read_data  output  DATA_WIDTH  requester 0 read result; valid while m0_ack=1, held afterwards.
- m1_req, m1_wEn, m1_address, m1_write_data, m1_ack, m1_read_data  same as the m0 ports, for requester 1.
- wEn  output  1  ram data-port write enable.
- d_address  output  ADDR_WIDTH  ram data-port address.
- d_write_data  output  DATA_WIDTH  ram data-port write data.
- d_read_data  input  DATA_WIDTH  ram data-port read data; combinational from d_address.
- busy  output  1  high in ACCESS and DONE.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie), grant_id=0.
  - m0_ack=m1_ack=0, m0_read_data=m1_read_data=0.
  - wEn=0, d_address=0, d_write_data=0, busy=0.
- State IDLE:
  - If any req is high, pick the winner: a single requester wins outright; if both are high, the winner is the requester that is not last_grant.
  - On the edge: grant_id<=winner, last_grant<=winner, capture the winner's address, write data and wEn into d_address, d_write_data and a pending-write flag. Go to ACCESS.
  - If no req is high, stay in IDLE with wEn=0.
- State ACCESS (1 cycle):
  - wEn = pending-write flag (combinational from state, high only in ACCESS). d_address and d_write_data hold the captured values.
  - For a write, the ram commits on the edge that ends ACCESS.
  - For a read, d_read_data is captured on that edge into m{grant_id}_read_data. The other requester's read_data is unchanged.
  - For a write, read_data is unchanged.
  - Go to DONE.
- State DONE (1 cycle):
  - m{grant_id}_ack=1; wEn=0. Go to IDLE.
- Total latency: req sampled in IDLE, ack 2 cycles later. Back-to-back throughput is 1 transaction per 3 cycles.
- Handshake rules:
  - A requester keeps req and its request fields stable until it sees ack, then drops req or presents a new request on the following cycle.
  - The request fields are captured in IDLE, so changes after the grant edge have no effect on the transaction in flight.
  - req changes during ACCESS/DONE are ignored until IDLE.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1. No requester waits more than one transaction.
- Reset in ACCESS: wEn drops immediately, no write occurs, no ack is issued, and the transaction is lost. Reset in DONE: ack drops immediately.
- Address/data pass through unmodified; there is no width conversion. ADDR_WIDTH bounds the wrap of the address.

Test Plan:
- Reset then single write: m0 writes address 16, data 8 → wEn=1 for exactly one cycle with d_address=16 and d_write_data=8; m0_ack pulses 2 cycles after req is sampled; m1_ack stays 0.
- Read-back: m0 reads address 16 → m0_read_data=0x00000008 with m0_ack=1; wEn stays 0 for the whole transaction.
- Simultaneous requests after reset: m0 writes address 20 with data 32, m1 writes address 24 with data 31 → m0 is served first, then m1. Reading back gives 20→0x20 and 24→0x1F.
- Continuous contention for 4 transactions: m0 reads address 20, m1 reads address 24 → grant order 0,1,0,1. m0_read_data=0x20 and m1_read_data=0x1F; each requester's read_data is untouched by the other's transactions.
- Reset mid-ACCESS: m1 writes address 28 with data 11 and reset is asserted during ACCESS → wEn falls immediately and no ack is issued. A subsequent m1 read of address 28 returns the prior content (0), not 11.
- Field change after grant: m0 writes address 32 with data 1, then m0_address changes to 36 during ACCESS → the write lands at address 32; reading back gives 32→0x1 and 36 unchanged.
